// File: rtl/shapool_pkg.sv
// Shared definitions for the nonce sequencer and the hashing pool:
// sequencer state encoding, outstanding-attempt depth and the hit priority encoder.
package shapool_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN,
    SEQ_FOUND,
    SEQ_EXHAUSTED
  } seq_state_e;

  localparam int OUTSTANDING_DEPTH = 2;

  // Index of the lowest set bit; returns 0 when nothing is set.
  function automatic int lowest_set_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/nonce_sequencer_if.sv
// Nonce issue / completion channel between the sequencer (master) and the hashing pool (slave).
interface nonce_sequencer_if #(
  parameter int LOW_WIDTH      = 30,
  parameter int POOL_SIZE_LOG2 = 2
);
  logic                          nonce_valid;
  logic                          nonce_ready;
  logic [LOW_WIDTH-1:0]          nonce_low;
  logic                          done;
  logic [2**POOL_SIZE_LOG2-1:0]  hit;

  modport master (output nonce_valid, nonce_low, input nonce_ready, done, hit);
  modport slave  (input nonce_valid, nonce_low, output nonce_ready, done, hit);
endinterface

// File: rtl/nonce_fifo.sv
// Depth-2 queue of low nonces whose pool attempts are still outstanding;
// supports push and pop in the same cycle, including when full.
module nonce_fifo
  import shapool_pkg::*;
#(
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [OUTSTANDING_DEPTH];
  logic [WIDTH-1:0] mem_d [OUTSTANDING_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(OUTSTANDING_DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(do_push) - 2'(do_pop);
    if (clr) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/nonce_sequencer.sv
// Issues the shared low nonce range into the pool and captures the exact winning nonce.
// Optional feature: NONCE_SEQUENCER_ATTEMPT_COUNT_EN adds a saturating attempts counter output.
module nonce_sequencer
  import shapool_pkg::*;
#(
  parameter  int NONCE_WIDTH    = 32,
  parameter  int POOL_SIZE_LOG2 = 2,
  localparam int LOW_WIDTH      = NONCE_WIDTH - POOL_SIZE_LOG2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [LOW_WIDTH-1:0]   nonce_first,
  input  logic [LOW_WIDTH-1:0]   nonce_last,
  nonce_sequencer_if.master      pool,
  output logic                   busy,
  output logic                   result_valid,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  output logic                   exhausted,
  output logic                   protocol_error
`ifdef NONCE_SEQUENCER_ATTEMPT_COUNT_EN
  ,
  output logic [31:0]            attempts
`endif
);

  seq_state_e                state_q, state_d;
  logic [LOW_WIDTH-1:0]      cnt_q, cnt_d;
  logic [LOW_WIDTH-1:0]      lim_q, lim_d;
  logic                      busy_q, busy_d;
  logic                      result_valid_q, result_valid_d;
  logic [NONCE_WIDTH-1:0]    result_nonce_q, result_nonce_d;
  logic                      exhausted_q, exhausted_d;
  logic                      protocol_error_q, protocol_error_d;
  logic [1:0]                fifo_count;
  logic [LOW_WIDTH-1:0]      fifo_head;
  logic [POOL_SIZE_LOG2-1:0] hit_idx;
  logic                      issue, push, pop, take_hit;

  nonce_fifo #(.WIDTH(LOW_WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .push    (push),
    .pop     (pop),
    .din     (cnt_q),
    .head    (fifo_head),
    .count   (fifo_count)
  );

  always_comb begin
    pop      = pool.done && (fifo_count != 2'd0);
    // A completing attempt frees a slot in the same cycle, so issue can continue.
    issue    = (state_q == SEQ_RUN) && ((fifo_count < 2'(OUTSTANDING_DEPTH)) || pool.done);
    push     = issue && pool.nonce_ready;
    take_hit = pop && (|pool.hit) && ((state_q == SEQ_RUN) || (state_q == SEQ_DRAIN));
    hit_idx  = POOL_SIZE_LOG2'(lowest_set_idx(32'(pool.hit)));

    state_d          = state_q;
    cnt_d            = cnt_q;
    lim_d            = lim_q;
    result_valid_d   = result_valid_q;
    result_nonce_d   = result_nonce_q;
    exhausted_d      = exhausted_q;
    protocol_error_d = protocol_error_q | (pool.done && (fifo_count == 2'd0));

    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          cnt_d = nonce_first;
          lim_d = nonce_last;
          if (nonce_first > nonce_last) begin
            state_d     = SEQ_EXHAUSTED;
            exhausted_d = 1'b1;
          end else begin
            state_d = SEQ_RUN;
          end
        end
      end
      SEQ_RUN: begin
        // Stopping at the limit rather than incrementing keeps all-ones from wrapping.
        if (push) begin
          if (cnt_q == lim_q) state_d = SEQ_DRAIN;
          else                cnt_d   = cnt_q + LOW_WIDTH'(1);
        end
      end
      SEQ_DRAIN: begin
        if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
          state_d     = SEQ_EXHAUSTED;
          exhausted_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (take_hit) begin
      state_d        = SEQ_FOUND;
      exhausted_d    = 1'b0;
      result_valid_d = 1'b1;
      result_nonce_d = {hit_idx, fifo_head};
    end

    busy_d = (state_d == SEQ_RUN) || (state_d == SEQ_DRAIN);

    if (clear) begin
      state_d          = SEQ_IDLE;
      cnt_d            = '0;
      lim_d            = '0;
      busy_d           = 1'b0;
      result_valid_d   = 1'b0;
      result_nonce_d   = '0;
      exhausted_d      = 1'b0;
      protocol_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= SEQ_IDLE;
      cnt_q            <= '0;
      lim_q            <= '0;
      busy_q           <= 1'b0;
      result_valid_q   <= 1'b0;
      result_nonce_q   <= '0;
      exhausted_q      <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      lim_q            <= lim_d;
      busy_q           <= busy_d;
      result_valid_q   <= result_valid_d;
      result_nonce_q   <= result_nonce_d;
      exhausted_q      <= exhausted_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign pool.nonce_valid = issue;
  assign pool.nonce_low   = cnt_q;
  assign busy             = busy_q;
  assign result_valid     = result_valid_q;
  assign result_nonce     = result_nonce_q;
  assign exhausted        = exhausted_q;
  assign protocol_error   = protocol_error_q;

`ifdef NONCE_SEQUENCER_ATTEMPT_COUNT_EN
  logic [31:0] attempts_q, attempts_d;

  always_comb begin
    attempts_d = attempts_q;
    if (clear || ((state_q == SEQ_IDLE) && start)) attempts_d = '0;
    else if (pop && (attempts_q != 32'hFFFF_FFFF)) attempts_d = attempts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) attempts_q <= '0;
    else          attempts_q <= attempts_d;
  end

  assign attempts = attempts_q;
`endif

endmodule

// File: tb/tb_nonce_sequencer.sv
// Bench for nonce_sequencer: acts as the hashing pool and compares the DUT against a
// queue-based model of issued/outstanding nonces.
module tb_nonce_sequencer;
  localparam int NONCE_WIDTH    = 32;
  localparam int POOL_SIZE_LOG2 = 2;
  localparam int LOW_WIDTH      = NONCE_WIDTH - POOL_SIZE_LOG2;
  localparam logic [LOW_WIDTH-1:0] LOW_ONES = {LOW_WIDTH{1'b1}};

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic                 clear;
  logic [LOW_WIDTH-1:0] nonce_first;
  logic [LOW_WIDTH-1:0] nonce_last;
  logic                 busy;
  logic                 result_valid;
  logic [31:0]          result_nonce;
  logic                 exhausted;
  logic                 protocol_error;
`ifdef NONCE_SEQUENCER_ATTEMPT_COUNT_EN
  logic [31:0]          attempts;
`endif

  nonce_sequencer_if #(.LOW_WIDTH(LOW_WIDTH), .POOL_SIZE_LOG2(POOL_SIZE_LOG2)) pif ();

  nonce_sequencer #(.NONCE_WIDTH(NONCE_WIDTH), .POOL_SIZE_LOG2(POOL_SIZE_LOG2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .clear          (clear),
    .nonce_first    (nonce_first),
    .nonce_last     (nonce_last),
    .pool           (pif),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_nonce   (result_nonce),
    .exhausted      (exhausted),
    .protocol_error (protocol_error)
`ifdef NONCE_SEQUENCER_ATTEMPT_COUNT_EN
    ,
    .attempts       (attempts)
`endif
  );

  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int dut_issues;

  // Reference model state
  logic [LOW_WIDTH-1:0] m_next, m_last;
  bit                   m_started, m_issue_done, m_found, m_exh, m_perr;
  logic [31:0]          m_res;
  logic [LOW_WIDTH-1:0] m_q[$];
  int                   m_t[$];

  function automatic int ref_lowest(input logic [3:0] h);
    for (int i = 0; i < 4; i++) if (h[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_started = 0; m_issue_done = 0; m_found = 0; m_exh = 0; m_perr = 0;
    m_res = '0; m_next = '0; m_last = '0;
    m_q.delete();
    m_t.delete();
  endtask

  // One clock: drive pool inputs at the falling edge, check the offer, advance the model.
  task automatic step(input bit rdy, input bit dn, input logic [3:0] h);
    bit exp_v;
    bit acc;
    logic [LOW_WIDTH-1:0] head;
    pif.nonce_ready = rdy;
    pif.done        = dn;
    pif.hit         = h;
    #1;
    exp_v = m_started && !m_issue_done && !m_found && !m_exh && (m_q.size() < 2 || dn);
    checks++;
    if (pif.nonce_valid !== exp_v) begin
      errors++;
      $display("FAIL nonce_valid cyc=%0d got %b expected %b", cyc, pif.nonce_valid, exp_v);
    end
    if (exp_v) begin
      checks++;
      if (pif.nonce_low !== m_next) begin
        errors++;
        $display("FAIL nonce_low cyc=%0d got %h expected %h", cyc, pif.nonce_low, m_next);
      end
    end
    if (pif.nonce_valid === 1'b1 && rdy) dut_issues++;
    acc = exp_v && rdy;
    @(posedge clk);
    cyc++;
    if (dn) begin
      if (m_q.size() == 0) m_perr = 1;
      else begin
        head = m_q.pop_front();
        void'(m_t.pop_front());
        if (h != 4'h0 && !m_found && !m_exh) begin
          m_found = 1;
          m_res   = {2'(ref_lowest(h)), head};
        end
      end
    end
    if (acc) begin
      m_q.push_back(m_next);
      m_t.push_back(cyc);
      if (m_next == m_last) m_issue_done = 1;
      else m_next = m_next + 1'b1;
    end
    if (m_started && m_issue_done && !m_found && !m_exh && m_q.size() == 0) m_exh = 1;
    @(negedge clk);
    checks++;
    if (result_valid !== m_found) begin
      errors++;
      $display("FAIL result_valid cyc=%0d got %b expected %b", cyc, result_valid, m_found);
    end
    checks++;
    if (result_nonce !== (m_found ? m_res : 32'h0)) begin
      errors++;
      $display("FAIL result_nonce cyc=%0d got %h expected %h", cyc, result_nonce, m_found ? m_res : 32'h0);
    end
    checks++;
    if (exhausted !== m_exh) begin
      errors++;
      $display("FAIL exhausted cyc=%0d got %b expected %b", cyc, exhausted, m_exh);
    end
    checks++;
    if (busy !== (m_started && !m_found && !m_exh)) begin
      errors++;
      $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, m_started && !m_found && !m_exh);
    end
    checks++;
    if (protocol_error !== m_perr) begin
      errors++;
      $display("FAIL protocol_error cyc=%0d got %b expected %b", cyc, protocol_error, m_perr);
    end
  endtask

  task automatic do_start(input logic [LOW_WIDTH-1:0] f, input logic [LOW_WIDTH-1:0] l);
    nonce_first     = f;
    nonce_last      = l;
    start           = 1'b1;
    pif.done        = 1'b0;
    pif.hit         = 4'h0;
    pif.nonce_ready = 1'($urandom);
    #1;
    checks++;
    if (pif.nonce_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_valid got %b expected 0", pif.nonce_valid);
    end
    @(posedge clk);
    cyc++;
    model_reset();
    m_next = f; m_last = l; m_started = 1; m_exh = (f > l);
    dut_issues = 0;
    @(negedge clk);
    start       = 1'b0;
    nonce_first = LOW_WIDTH'($urandom);
    nonce_last  = LOW_WIDTH'($urandom);
    checks++;
    if (busy !== !(f > l) || exhausted !== (f > l)) begin
      errors++;
      $display("FAIL start_state busy=%b exhausted=%b expected busy=%b exhausted=%b", busy, exhausted, !(f > l), f > l);
    end
    checks++;
    if (pif.nonce_low !== f) begin
      errors++;
      $display("FAIL start_low got %h expected %h", pif.nonce_low, f);
    end
  endtask

  task automatic do_clear();
    clear           = 1'b1;
    pif.done        = 1'b0;
    pif.nonce_ready = 1'b0;
    pif.hit         = 4'h0;
    @(posedge clk);
    cyc++;
    model_reset();
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({busy, result_valid, exhausted, protocol_error, pif.nonce_valid} !== 5'b0 ||
        result_nonce !== 32'h0 || pif.nonce_low !== '0) begin
      errors++;
      $display("FAIL clear_outputs flags=%b result=%h low=%h expected all zero",
               {busy, result_valid, exhausted, protocol_error, pif.nonce_valid}, result_nonce, pif.nonce_low);
    end
  endtask

  // Pool behaviour: fixed done latency with ready held high (delay>0) or random timing.
  task automatic run_pool(input int delay, input logic [LOW_WIDTH-1:0] target,
                          input logic [3:0] hitv, input int budget, output int n);
    bit rdy, dn;
    logic [3:0] h;
    n = 0;
    while (!((m_found || m_exh) && m_q.size() == 0) && n < budget) begin
      if (delay > 0) begin
        rdy = 1;
        dn  = (m_q.size() > 0) && (cyc + 1 >= m_t[0] + delay);
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        dn  = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      end
      if (dn) h = (m_q[0] == target) ? hitv : (m_found ? 4'($urandom_range(1, 15)) : 4'h0);
      else    h = 4'($urandom);
      step(rdy, dn, h);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL run_timeout after %0d cycles, required completion", n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; clear = 1'b0;
    nonce_first = '0; nonce_last = '0;
    pif.nonce_ready = 1'b0; pif.done = 1'b0; pif.hit = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, result_valid, exhausted, protocol_error, pif.nonce_valid} !== 5'b0 ||
        result_nonce !== 32'h0 || pif.nonce_low !== '0) begin
      errors++;
      $display("FAIL reset_outputs flags=%b result=%h low=%h expected all zero",
               {busy, result_valid, exhausted, protocol_error, pif.nonce_valid}, result_nonce, pif.nonce_low);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exhaust_range();
    int n;
    do_start(30'h10, 30'h13);
    run_pool(3, LOW_ONES, 4'h0, 200, n);
    checks++;
    if (dut_issues !== 4) begin
      errors++;
      $display("FAIL exhaust_issues got %0d expected 4", dut_issues);
    end
    checks++;
    if (exhausted !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_final exhausted=%b result_valid=%b expected 1/0", exhausted, result_valid);
    end
    do_clear();
  endtask

  task automatic test_hit();
    int n;
    do_start(30'h10, 30'h13);
    run_pool(3, 30'h12, 4'b0110, 200, n);
    checks++;
    if (result_valid !== 1'b1 || result_nonce !== 32'h4000_0012) begin
      errors++;
      $display("FAIL hit_result valid=%b nonce=%h expected 1/40000012", result_valid, result_nonce);
    end
    checks++;
    if (exhausted !== 1'b0) begin
      errors++;
      $display("FAIL hit_exhausted got %b expected 0", exhausted);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(30'h40, 30'h4F);
    run_pool(1, LOW_ONES, 4'h0, 200, n);
    checks++;
    if (n !== 17 || dut_issues !== 16) begin
      errors++;
      $display("FAIL back_to_back cycles=%0d issues=%0d expected 17/16", n, dut_issues);
    end
    do_clear();
  endtask

  task automatic test_backpressure();
    do_start(30'h100, 30'h1FF);
    repeat (6) step(1'b1, 1'b0, 4'($urandom));
    checks++;
    if (dut_issues !== 2) begin
      errors++;
      $display("FAIL backpressure_issues got %0d expected 2", dut_issues);
    end
    step(1'b1, 1'b1, 4'h0);
    checks++;
    if (dut_issues !== 3) begin
      errors++;
      $display("FAIL backpressure_reissue got %0d expected 3", dut_issues);
    end
    do_clear();
  endtask

  task automatic test_no_wrap();
    int n;
    do_start(LOW_ONES, LOW_ONES);
    run_pool(2, 30'h0, 4'hF, 100, n);
    checks++;
    if (dut_issues !== 1 || exhausted !== 1'b1 || pif.nonce_low !== LOW_ONES) begin
      errors++;
      $display("FAIL no_wrap issues=%0d exhausted=%b low=%h expected 1/1/%h",
               dut_issues, exhausted, pif.nonce_low, LOW_ONES);
    end
    do_clear();
  endtask

  task automatic test_empty_range();
    do_start(30'd5, 30'd4);
    repeat (3) step(1'b1, 1'b0, 4'h0);
    checks++;
    if (dut_issues !== 0) begin
      errors++;
      $display("FAIL empty_issues got %0d expected 0", dut_issues);
    end
    step(1'b0, 1'b1, 4'h0);
    checks++;
    if (protocol_error !== 1'b1 || exhausted !== 1'b1) begin
      errors++;
      $display("FAIL empty_protocol perr=%b exhausted=%b expected 1/1", protocol_error, exhausted);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    int n;
    do_start(30'h20, 30'h40);
    repeat (3) step(1'b1, 1'b0, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, result_valid, exhausted, protocol_error, pif.nonce_valid} !== 5'b0 ||
        result_nonce !== 32'h0 || pif.nonce_low !== '0) begin
      errors++;
      $display("FAIL async_reset flags=%b result=%h low=%h expected all zero",
               {busy, result_valid, exhausted, protocol_error, pif.nonce_valid}, result_nonce, pif.nonce_low);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(30'h300, 30'h305);
    run_pool(0, 30'h301, 4'b1000, 500, n);
    checks++;
    if (result_nonce !== 32'hC000_0301) begin
      errors++;
      $display("FAIL post_reset_result got %h expected c0000301", result_nonce);
    end
    do_clear();
  endtask

  task automatic test_random();
    int n;
    logic [LOW_WIDTH-1:0] f, l, tgt;
    int len;
    for (int it = 0; it < 8; it++) begin
      f   = LOW_WIDTH'($urandom_range(1, 2000));
      len = $urandom_range(0, 10);
      l   = (it == 5) ? f - 1'b1 : f + LOW_WIDTH'(len);
      tgt = f + LOW_WIDTH'($urandom_range(0, len + 3));
      do_start(f, l);
      run_pool((it % 2 == 0) ? 0 : $urandom_range(1, 4), tgt, 4'($urandom_range(1, 15)), 600, n);
      do_clear();
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; dut_issues = 0;
    test_reset();
    test_exhaust_range();
    test_hit();
    test_back_to_back();
    test_backpressure();
    test_no_wrap();
    test_empty_range();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
